itof: RTL and testbench

- Pipelined signed 32-bit integer to IEEE-754 single-precision converter. It is the inverse of the existing ftoi unit.
- It sits in the FPU beside ftoi and serves the cvt.s.w-class instruction.
- It has a valid/ready handshake on both sides, so the FPU writeback arbiter can stall it without losing data.
- Rounding is round-to-nearest-even. Exceptions and flags are not produced.

---
 rtl/itof_pkg.sv | 29 ++
 rtl/itof_lzc32.sv | 24 ++
 rtl/itof.sv | 94 +++++++++
 tb/tb_itof.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/itof_pkg.sv
// Shared types and constants for the integer-to-float converter.
// float32_t and FLOAT_BIAS are intended for reuse by ftoi.
package itof_pkg;
  localparam int FLOAT_BIAS = 127;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;

  // Exponent of a value whose leading one sits at bit 31.
  localparam logic [EXP_W-1:0] EXP_TOP = 8'(FLOAT_BIAS + 31);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float32_t;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [31:0] mag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [EXP_W-1:0] e;
    logic [31:0]      norm;
  } s2_t;
endpackage

// File: rtl/itof_lzc32.sv
// Combinational 32-bit leading-zero counter, binary-halving tree.
// Returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  out
);
  logic [15:0] v16;
  logic [7:0]  v8;
  logic [3:0]  v4;
  logic [1:0]  v2;
  logic        z16, z8, z4, z2, z1;

  assign z16 = ~|a[31:16];
  assign v16 = z16 ? a[15:0] : a[31:16];
  assign z8  = ~|v16[15:8];
  assign v8  = z8 ? v16[7:0] : v16[15:8];
  assign z4  = ~|v8[7:4];
  assign v4  = z4 ? v8[3:0] : v8[7:4];
  assign z2  = ~|v4[3:2];
  assign v2  = z2 ? v4[1:0] : v4[3:2];
  assign z1  = ~v2[1];

  assign out = (a == 32'd0) ? 6'd32 : {1'b0, z16, z8, z4, z2, z1};
endmodule

// File: rtl/itof.sv
// Three-stage signed int32 to IEEE-754 single converter with elastic
// valid/ready flow control on every stage.
module itof
  import itof_pkg::*;
#(
  parameter int NSTAGE    = 3,
  parameter bit ROUND_RNE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);
  if (NSTAGE != 3) begin : g_bad_nstage
    $error("itof: NSTAGE must be 3");
  end

  logic     v1, v2, v3;
  logic     load2, load3, adv1, adv2;
  s1_t      s1, s1_d;
  s2_t      s2, s2_d;
  float32_t y_r, y_d;
  logic [5:0] lz;

  // Each stage loads when empty or when its successor takes its content.
  assign load3    = !v3 || out_ready;
  assign adv2     = v2 && load3;
  assign load2    = !v2 || adv2;
  assign adv1     = v1 && load2;
  assign in_ready = !v1 || adv1;

  always_comb begin
    s1_d.sign = x[31];
    s1_d.zero = (x == 32'd0);
    s1_d.mag  = x[31] ? (~x + 32'd1) : x;
  end

  lzc32 u_lzc (
    .a   (s1.mag),
    .out (lz)
  );

  always_comb begin
    s2_d.sign = s1.sign;
    s2_d.zero = s1.zero;
    s2_d.e    = EXP_TOP - {2'b00, lz};
    s2_d.norm = s1.mag << lz;
  end

  logic [MANT_W:0]   sig;
  logic [MANT_W+1:0] sig_sum;
  logic              guard, sticky, rup, carry;

  always_comb begin
    sig     = s2.norm[31:8];
    guard   = s2.norm[7];
    sticky  = |s2.norm[6:0];
    rup     = ROUND_RNE && guard && (sticky || sig[0]);
    sig_sum = {1'b0, sig} + {{(MANT_W+1){1'b0}}, rup};
    // A carry out of the significand renormalises by one place.
    carry   = sig_sum[MANT_W+1];
    y_d     = '0;
    if (!s2.zero) begin
      y_d.sign = s2.sign;
      y_d.exp  = s2.e + {{(EXP_W-1){1'b0}}, carry};
      y_d.mant = carry ? sig_sum[MANT_W:1] : sig_sum[MANT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      s1  <= '0;
      s2  <= '0;
      y_r <= '0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (in_valid && in_ready) s1 <= s1_d;
      if (load2) v2 <= v1;
      if (adv1) s2 <= s2_d;
      if (load3) v3 <= v2;
      if (adv2) y_r <= y_d;
    end
  end

  assign out_valid = v3;
  assign y         = y_r;
endmodule

// File: tb/tb_itof.sv
// Self-checking bench for itof: directed vectors, flow-control sequences,
// asynchronous reset and randomized traffic against a real-arithmetic model.
module tb_itof;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready_t;
  logic [31:0] x;
  logic        out_valid, out_valid_t;
  logic        out_ready = 1'b1;
  logic [31:0] y, y_t;

  itof #(.NSTAGE(3), .ROUND_RNE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  itof #(.NSTAGE(3), .ROUND_RNE(1'b0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .x(x),
    .out_valid(out_valid_t), .out_ready(out_ready), .y(y_t)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Convert through double precision (exact for any int32), then round to single.
  function automatic logic [31:0] ref_f(input logic [31:0] xi, input bit rne);
    logic [63:0] d;
    logic [7:0]  e;
    logic [22:0] m;
    logic [28:0] rem;
    if (xi == 32'd0) return 32'd0;
    d   = $realtobits($itor($signed(xi)));
    e   = 8'(d[62:52] - 11'd896);
    m   = d[51:29];
    rem = d[28:0];
    if (rne && (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0]))) begin
      if (m == '1) begin
        m = '0;
        e = e + 8'd1;
      end else begin
        m = m + 23'd1;
      end
    end
    return {d[63], e, m};
  endfunction

  // out_ready source: 0 = hold or_val, 1 = random
  int   or_mode = 0;
  logic or_val  = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = (or_mode == 1) ? ($urandom_range(0, 3) != 0) : or_val;
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] er;
    logic [31:0] et;
    int          c;
  } sb_t;
  sb_t sb[$];

  logic [31:0] cur_er, cur_et;
  int   cyc = 0;
  bit   chk_lat = 0;
  bit   chk_b2b = 0;
  int   last_out = -1;
  bit   prev_stall = 0;
  logic [31:0] prev_y;

  always @(negedge clk) begin
    sb_t e;
    cyc++;
    if (rst) begin
      prev_stall = 0;
    end else begin
      chk("in_ready", in_ready, (sb.size() < 3) || out_ready);
      chk("trunc_hs", {in_ready_t, out_valid_t}, {in_ready, out_valid});
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_y", y, prev_y);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("y_rne", y, e.er);
          chk("y_trunc", y_t, e.et);
          if (chk_lat) chk("latency", 32'(cyc - e.c), 32'd3);
          if (chk_b2b && last_out >= 0) chk("back2back", 32'(cyc - last_out), 32'd1);
          last_out = cyc;
        end
      end
      if (in_valid && in_ready) sb.push_back('{x, cur_er, cur_et, cyc});
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
    end
  end

  task automatic send(input logic [31:0] xv, input logic [31:0] er, input logic [31:0] et);
    x        = xv;
    cur_er   = er;
    cur_et   = et;
    in_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_r(input logic [31:0] xv);
    send(xv, ref_f(xv, 1'b1), ref_f(xv, 1'b0));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] yt;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[1]  = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000};
    tbl[2]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000};
    tbl[3]  = '{32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000};
    tbl[4]  = '{32'h0100_0001, 32'h4B80_0000, 32'h4B80_0000};
    tbl[5]  = '{32'h0100_0003, 32'h4B80_0002, 32'h4B80_0001};
    tbl[6]  = '{32'h0100_0005, 32'h4B80_0002, 32'h4B80_0002};
    tbl[7]  = '{32'h0100_0007, 32'h4B80_0004, 32'h4B80_0003};
    tbl[8]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 32'h4EFF_FFFF};
    tbl[9]  = '{32'h00FF_FFFF, 32'h4B7F_FFFF, 32'h4B7F_FFFF};
    tbl[10] = '{32'hFEFF_FFFF, 32'hCB80_0000, 32'hCB80_0000};
    tbl[11] = '{32'h0000_0005, 32'h40A0_0000, 32'h40A0_0000};

    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    #3;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_y", y, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    idle();

    // Directed values, one per cycle, fixed latency
    chk_lat = 1;
    foreach (tbl[i]) send(tbl[i].x, tbl[i].y, tbl[i].yt);
    drain();
    chk_lat = 0;

    // Output stalled in the middle of a 10-item stream
    fork
      begin
        for (int i = 0; i < 10; i++) send_r(32'((i + 1) * 32'h0123_4567 + 32'(i)));
      end
      begin
        repeat (3) @(posedge clk);
        or_val = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_held", 32'(sb.size()), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        or_val = 1'b1;
      end
    join
    drain();

    // Sparse input while stalled: pipeline compacts, then drains back-to-back
    or_val = 1'b0;
    repeat (2) idle();
    fork
      begin
        send_r(32'd100);
        idle();
        send_r(32'hFFFF_FF9C);
        idle();
        send_r(32'h0300_0001);
        idle();
        send_r(32'd77);
      end
      begin
        repeat (14) @(negedge clk);
        chk("bub_held", 32'(sb.size()), 32'd3);
        chk("bub_in_ready", 32'(in_ready), 32'd0);
        chk_b2b  = 1;
        last_out = -1;
        @(posedge clk);
        or_val = 1'b1;
      end
    join
    drain();
    chk_b2b = 0;

    // Asynchronous reset with a full pipeline
    or_val = 1'b0;
    idle();
    send_r(32'd11);
    send_r(32'd22);
    send_r(32'd33);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_y", y, 32'd0);
    chk("mid_rst_y_t", y_t, 32'd0);
    sb.delete();
    or_val = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    idle();
    chk_lat = 1;
    send(32'd5, 32'h40A0_0000, 32'h40A0_0000);
    drain();
    chk_lat = 0;

    // Randomized traffic with random backpressure
    or_mode = 1;
    for (int i = 0; i < 20000; i++) begin
      logic [31:0] xv;
      case ($urandom_range(0, 3))
        0: xv = $urandom;
        1: xv = $urandom >> $urandom_range(0, 31);
        2: xv = -($urandom >> $urandom_range(0, 31));
        default: xv = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 3)) - 32'd1;
      endcase
      send_r(xv);
      if ($urandom_range(0, 4) == 0) idle();
    end
    or_mode = 0;
    or_val  = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
